// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the instruction memory address and buffers
// fetched words in a 2-entry prefetch queue for decode. Optional halt detection: FETCH_HALT_EN.
module inst_fetch_ctrl #(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        INST_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INST_W-1:0]  HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [1:0] CNT_FULL = 2'd2;

    // Queue head lives directly in the output registers; the tail holds the second entry.
    logic [ADDR_W-1:0] r_fpc,       w_fpc_nxt;
    logic [1:0]        r_count,     w_count_nxt;
    logic              r_halt,      w_halt_nxt;
    logic              r_halted,    w_halted_nxt;
    logic [INST_W-1:0] r_head_inst, w_head_inst_nxt;
    logic [ADDR_W-1:0] r_head_pc,   w_head_pc_nxt;
    logic [INST_W-1:0] r_tail_inst, w_tail_inst_nxt;
    logic [ADDR_W-1:0] r_tail_pc,   w_tail_pc_nxt;
    logic              w_deq;
    logic              w_cap;

    always_comb begin
        w_fpc_nxt       = r_fpc;
        w_count_nxt     = r_count;
        w_halt_nxt      = r_halt;
        w_head_inst_nxt = r_head_inst;
        w_head_pc_nxt   = r_head_pc;
        w_tail_inst_nxt = r_tail_inst;
        w_tail_pc_nxt   = r_tail_pc;

        w_deq = (r_count != 2'd0) && out_ready;
        w_cap = !redirect_valid && !r_halt && ((r_count != CNT_FULL) || w_deq);

        if (redirect_valid) begin
            w_count_nxt = 2'd0;
            w_fpc_nxt   = redirect_pc;
            w_halt_nxt  = 1'b0;
        end else begin
            if (w_cap) begin
                w_fpc_nxt = r_fpc + ADDR_W'(1);
                if (HALT_EN && (mem_inst == HALT_WORD)) begin
                    w_halt_nxt = 1'b1;
                end
            end
            case ({w_deq, w_cap})
                2'b01: begin
                    if (r_count == 2'd0) begin
                        w_head_inst_nxt = mem_inst;
                        w_head_pc_nxt   = r_fpc;
                    end else begin
                        w_tail_inst_nxt = mem_inst;
                        w_tail_pc_nxt   = r_fpc;
                    end
                    w_count_nxt = r_count + 2'd1;
                end
                2'b10: begin
                    if (r_count == CNT_FULL) begin
                        w_head_inst_nxt = r_tail_inst;
                        w_head_pc_nxt   = r_tail_pc;
                    end
                    w_count_nxt = r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; at full the tail advances so order is kept.
                    if (r_count == CNT_FULL) begin
                        w_head_inst_nxt = r_tail_inst;
                        w_head_pc_nxt   = r_tail_pc;
                        w_tail_inst_nxt = mem_inst;
                        w_tail_pc_nxt   = r_fpc;
                    end else begin
                        w_head_inst_nxt = mem_inst;
                        w_head_pc_nxt   = r_fpc;
                    end
                end
                default: ;
            endcase
        end

        w_halted_nxt = HALT_EN && w_halt_nxt && (w_count_nxt == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc       <= RESET_PC;
            r_count     <= 2'd0;
            r_halt      <= 1'b0;
            r_halted    <= 1'b0;
            r_head_inst <= '0;
            r_head_pc   <= '0;
            r_tail_inst <= '0;
            r_tail_pc   <= '0;
        end else begin
            r_fpc       <= w_fpc_nxt;
            r_count     <= w_count_nxt;
            r_halt      <= w_halt_nxt;
            r_halted    <= w_halted_nxt;
            r_head_inst <= w_head_inst_nxt;
            r_head_pc   <= w_head_pc_nxt;
            r_tail_inst <= w_tail_inst_nxt;
            r_tail_pc   <= w_tail_pc_nxt;
        end
    end

    assign mem_addr  = r_fpc;
    assign out_valid = (r_count != 2'd0);
    assign out_inst  = r_head_inst;
    assign out_pc    = r_head_pc;
    assign halted    = r_halted;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: directed phases push expected {inst, pc} entries,
// a negedge monitor pops and compares on every accepted handshake.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mem_addr;
    logic [15:0] mem_inst;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [7:0]  out_pc;
    logic        halted;

    logic [15:0] mem [256];
    logic [23:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;
    assign mem_inst = mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] pc, input logic [15:0] inst);
        exp_q.push_back({inst, pc});
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step(1);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every accepted head must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_handshake_pc", 32'(out_pc), 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("sb_inst", 32'(out_inst), 32'(e[23:8]));
                chk("sb_pc",   32'(out_pc),   32'(e[7:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b1;

        // Reset values
        #12;
        chk("rst_mem_addr",  32'(mem_addr),  32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_inst",  32'(out_inst),  32'h0);
        chk("rst_out_pc",    32'(out_pc),    32'h0);
        chk("rst_halted",    32'(halted),    32'h0);

        // Streaming from reset
        for (int i = 0; i < 8; i++) push(8'(i), 16'h1000 + 16'(i));
        #8 rst_n = 1'b1;
        step(1);
        chk("first_valid", 32'(out_valid), 32'h1);
        chk("first_pc",    32'(out_pc),    32'h0);
        wait_empty("stream_drain");
        out_ready = 1'b0;

        // Backpressure after a restart at 0
        step(2);
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        step(1);
        redirect_valid = 1'b0;
        chk("bp_flush_valid", 32'(out_valid), 32'h0);
        chk("bp_flush_addr",  32'(mem_addr),  32'h00);
        step(1);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_pc0",   32'(out_pc),    32'h00);
        step(1);
        chk("bp_addr_full", 32'(mem_addr), 32'h02);
        step(3);
        chk("bp_addr_hold", 32'(mem_addr), 32'h02);
        chk("bp_head_hold", 32'(out_pc),   32'h00);
        for (int i = 0; i < 4; i++) push(8'(i), 16'h1000 + 16'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_release_valid", 32'(out_valid), 32'h1);
            chk("bp_release_pc",    32'(out_pc),    32'(i));
            step(1);
        end
        out_ready = 1'b0;

        // Redirect while full
        step(2);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        step(1);
        redirect_valid = 1'b0;
        chk("rd_valid_low", 32'(out_valid), 32'h0);
        chk("rd_addr",      32'(mem_addr),  32'h40);
        push(8'h40, 16'h1040); push(8'h41, 16'h1041); push(8'h42, 16'h1042);
        step(1);
        chk("rd_head_valid", 32'(out_valid), 32'h1);
        chk("rd_head_pc",    32'(out_pc),    32'h40);
        chk("rd_head_inst",  32'(out_inst),  32'h1040);
        out_ready = 1'b1;
        wait_empty("rd_drain");
        out_ready = 1'b0;

        // Address wrap-around
        step(2);
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        step(1);
        redirect_valid = 1'b0;
        push(8'hFE, 16'h10FE); push(8'hFF, 16'h10FF);
        push(8'h00, 16'h1000); push(8'h01, 16'h1001);
        out_ready = 1'b1;
        wait_empty("wrap_drain");
        out_ready = 1'b0;

        // Redirect together with a handshake: old head consumed, then new stream only
        step(2);
        push(8'h02, 16'h1002);
        push(8'h80, 16'h1080); push(8'h81, 16'h1081); push(8'h82, 16'h1082);
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        step(1);
        redirect_valid = 1'b0;
        chk("rdhs_valid_low", 32'(out_valid), 32'h0);
        step(1);
        chk("rdhs_head_pc", 32'(out_pc), 32'h80);
        wait_empty("rdhs_drain");
        out_ready = 1'b0;

        // Halt word at address 3
        mem[3] = 16'hFFFF;
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        step(1);
        redirect_valid = 1'b0;
        chk("halt_pre", 32'(halted), 32'h0);
        push(8'h00, 16'h1000); push(8'h01, 16'h1001);
        push(8'h02, 16'h1002); push(8'h03, 16'hFFFF);
`ifdef FETCH_HALT_EN
        out_ready = 1'b1;
        wait_empty("halt_drain");
        chk("halt_flag",  32'(halted),    32'h1);
        chk("halt_addr",  32'(mem_addr),  32'h04);
        chk("halt_valid", 32'(out_valid), 32'h0);
        step(2);
        chk("halt_addr_hold", 32'(mem_addr), 32'h04);
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        step(1);
        redirect_valid = 1'b0;
        chk("halt_cleared", 32'(halted), 32'h0);
        step(1);
        chk("halt_resume_valid", 32'(out_valid), 32'h1);
        chk("halt_resume_pc",    32'(out_pc),    32'h00);
`else
        push(8'h04, 16'h1004);
        out_ready = 1'b1;
        wait_empty("nohalt_drain");
        chk("nohalt_flag", 32'(halted), 32'h0);
        out_ready = 1'b0;
`endif

        // Asynchronous reset mid-operation
        step(2);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_addr",  32'(mem_addr),  32'h00);
        chk("arst_pc",    32'(out_pc),    32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer for the S-Machine CPU: owns the program counter, drives the 8-bit address of the combinational instruction memory, and buffers fetched 16-bit words in a 2-entry prefetch queue. The queue feeds decode through a valid/ready handshake. Decode/execute redirects fetch on branches and jumps. The block sustains one instruction per cycle when decode never stalls.

## Interface
Parameters:
- ADDR_W, 8, PC / memory address width
- INST_W, 16, instruction width
- RESET_PC, 8'h00, first fetch address after reset
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetch (only used with FETCH_HALT_EN)

Ports:
- clk  in  1  sole clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr  out  ADDR_W  address to instruction memory (equals fetch PC register)
- mem_inst  in  INST_W  instruction memory read data, combinational from mem_addr, same cycle
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  INST_W  queue head instruction
- out_pc  out  ADDR_W  address the head was fetched from
- halted  out  1  fetch stopped on HALT_WORD and queue drained

## Operation
- State: fetch PC `fpc`, 2-entry FIFO of {inst, pc}, occupancy count 0..2, halt flag.
- Reset (async, rst_n=0): fpc=RESET_PC, count=0, halt flag=0. Outputs: mem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, halted=0.
- mem_addr = fpc at all times.
- Dequeue: out_valid && out_ready removes the head.
- Capture condition: no redirect_valid, halt flag clear, and (count<2 or dequeue this cycle).
  - On capture, {mem_inst, fpc} is enqueued and fpc <= fpc+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00, no flag).
- Simultaneous dequeue and capture at count=2: count stays 2, and the order is preserved.
- Redirect (highest priority):
  - On redirect_valid=1 at an edge, count <= 0, fpc <= redirect_pc, halt flag <= 0, and no capture that cycle.
  - A head accepted in the same cycle as a redirect counts as consumed. Discarding it is decode's responsibility.
- out_valid = (count != 0). out_inst/out_pc are registered queue-head contents. They hold their last values when out_valid=0 (0 after reset).
- Backpressure: with out_ready=0, the queue fills to 2 and fetch stalls. fpc holds, and mem_addr is stable.

## Timing
- Reset release: first capture at the first edge. out_valid=1 with out_pc=RESET_PC in the following cycle (1-cycle fetch latency).
- Redirect asserted in cycle T: out_valid=0 in T+1, mem_addr=redirect_pc in T+1, and the head is redirect_pc with out_valid=1 in T+2.
- Steady state, out_ready held 1: one instruction per cycle, consecutive out_pc.
- Stall release: out_ready rising delivers the buffered head that cycle, with no bubble.
- Reset mid-operation: all state is discarded asynchronously, and the queue contents are lost.

## Configuration
- FETCH_HALT_EN defined:
  - A captured word equal to HALT_WORD is enqueued normally and sets the halt flag. Fetch then stops, and fpc holds at HALT address+1.
  - halted = halt flag && count==0.
  - A redirect clears the flag and resumes fetch.
- FETCH_HALT_EN undefined: no halt detection, HALT_WORD is unused, halted is tied to 0, and fetch runs forever, wrapping the address space.

## Test plan
- Reset/streaming: memory[i]=i+16'h1000, out_ready=1 → out_valid first high 1 cycle after reset release, out_pc 0,1,2… with out_inst 16'h1000,16'h1001,… one per cycle.
- Backpressure: out_ready=0 for 5 cycles after first valid → count saturates at 2, mem_addr holds 8'h02. On release, out_pc 0,1,2,3 appears on consecutive cycles with no gap or duplicate.
- Redirect: redirect_valid=1, redirect_pc=8'h40 while the queue is full → next cycle out_valid=0. The cycle after, out_pc=8'h40 with out_inst=memory[8'h40]. Old entries are never presented.
- Wrap-around: redirect to 8'hFE, out_ready=1 → out_pc FE, FF, 00, 01.
- Redirect during stall plus simultaneous handshake: out_ready=1 and redirect_valid=1 in the same cycle → only redirect_pc-stream entries follow, 2 cycles later.
- FETCH_HALT_EN: memory[3]=16'hFFFF → out_pc 0..3 delivered, mem_addr stays 8'h04, and halted=1 the cycle after entry 3 dequeues. A redirect to 8'h00 clears halted and fetch resumes. Without the macro, halted stays 0 and entry 4 follows.
